// File: rtl/cola_escritura_reg_pkg.sv
// Shared definitions for the dual-issue writeback queue.
//   CER_DATA_W / CER_ADDR_W : default result and register-index widths
//   entry_t                 : one pending write {dst, data}
//   WE_ACTIVE / WE_IDLE     : register-bank write-enable levels (active low)
package cola_escritura_reg_pkg;

    localparam int CER_DATA_W = 32;
    localparam int CER_ADDR_W = 5;

    typedef struct packed {
        logic [CER_ADDR_W-1:0] dst;
        logic [CER_DATA_W-1:0] data;
    } entry_t;

    localparam logic WE_ACTIVE = 1'b0;
    localparam logic WE_IDLE   = 1'b1;

endpackage

// File: rtl/cola_escritura_reg_if.sv
// Bus between the execution slots / register bank and the writeback queue.
//   in_valid_x, in_reg_x, in_data_x : results from slot 1 (older) and slot 2
//   in_ready                        : queue has room for two more entries
//   write_reg_flag_x                : active-low bank write enables
//   write_reg_x, write_data_x       : bank write address / data
// Modports: master = execution slots + bank side, slave = the queue.
interface cola_escritura_reg_if #(
    parameter int DATA_W = cola_escritura_reg_pkg::CER_DATA_W,
    parameter int ADDR_W = cola_escritura_reg_pkg::CER_ADDR_W
) ();

    logic              in_valid_1;
    logic              in_valid_2;
    logic [ADDR_W-1:0] in_reg_1;
    logic [ADDR_W-1:0] in_reg_2;
    logic [DATA_W-1:0] in_data_1;
    logic [DATA_W-1:0] in_data_2;
    logic              in_ready;

    logic              write_reg_flag_1;
    logic              write_reg_flag_2;
    logic [ADDR_W-1:0] write_reg_1;
    logic [ADDR_W-1:0] write_reg_2;
    logic [DATA_W-1:0] write_data_1;
    logic [DATA_W-1:0] write_data_2;

    modport master (
        output in_valid_1, in_valid_2, in_reg_1, in_reg_2, in_data_1, in_data_2,
        input  in_ready,
        input  write_reg_flag_1, write_reg_flag_2, write_reg_1, write_reg_2,
        input  write_data_1, write_data_2
    );

    modport slave (
        input  in_valid_1, in_valid_2, in_reg_1, in_reg_2, in_data_1, in_data_2,
        output in_ready,
        output write_reg_flag_1, write_reg_flag_2, write_reg_1, write_reg_2,
        output write_data_1, write_data_2
    );

endinterface

// File: rtl/cola_escritura_reg_lookup.sv
// Combinational youngest-match search over pending writes.
//   cand[]   : candidates ordered oldest (index 0) to youngest
//   cand_vld : which candidates hold a live pending write
//   look     : register index to search for (0 always misses)
//   hit/data : match found / value of the youngest match (0 on miss)
module cola_escritura_lookup
    import cola_escritura_reg_pkg::*;
#(
    parameter int NCAND = 6
) (
    input  entry_t                cand [NCAND],
    input  logic [NCAND-1:0]      cand_vld,
    input  logic [CER_ADDR_W-1:0] look,
    output logic                  hit,
    output logic [CER_DATA_W-1:0] data
);

    // Scanning oldest to youngest lets a later match overwrite an earlier one,
    // so the youngest pending value is what remains.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        if (look != '0) begin
            for (int i = 0; i < NCAND; i++) begin
                if (cand_vld[i] && (cand[i].dst == look)) begin
                    hit  = 1'b1;
                    data = cand[i].data;
                end
            end
        end
    end

endmodule

// File: rtl/cola_escritura_reg.sv
// Dual-issue writeback queue in front of the two register-bank write ports.
//   clk, reset_n        : clock, asynchronous active-low reset
//   bus (slave)         : two result slots in, two active-low bank write ports out
//   wb_stall            : hold retirement (queue keeps accepting)
//   look_rs / look_rt   : forwarding lookup indices
//   hit_x / data_x      : youngest pending write for the index (0 on miss)
//   count               : occupied queue entries
//   overflow            : sticky, set when a cycle's inputs were dropped
// Queue storage uses the package entry type, so DATA_W / ADDR_W must stay at
// the package defaults.
module cola_escritura_reg
    import cola_escritura_reg_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = CER_DATA_W,
    parameter int ADDR_W = CER_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    cola_escritura_reg_if.slave    bus,
    input  logic                   wb_stall,
    input  logic [ADDR_W-1:0]      look_rs,
    input  logic [ADDR_W-1:0]      look_rt,
    output logic                   hit_rs,
    output logic                   hit_rt,
    output logic [DATA_W-1:0]      data_rs,
    output logic [DATA_W-1:0]      data_rt,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NCAND = DEPTH + 2;

    // Pointers carry one extra wrap bit above the index.
    logic [PTR_W:0]   head_reg;
    logic [PTR_W:0]   tail_reg;
    logic             overflow_reg;
    entry_t           mem [DEPTH];

    entry_t           port1_reg;
    entry_t           port2_reg;
    logic             flag_1_reg;
    logic             flag_2_reg;

    logic [CNT_W-1:0] occupancy;
    logic             empty;
    logic             full;
    logic             in_ready_int;

    assign occupancy = tail_reg - head_reg;
    assign empty     = (head_reg == tail_reg);
    assign full      = (head_reg[PTR_W] != tail_reg[PTR_W]) &&
                       (head_reg[PTR_W-1:0] == tail_reg[PTR_W-1:0]);

    // Two free entries are required regardless of how many slots are valid,
    // and a same-cycle pop is not credited.
    assign in_ready_int = !full && (occupancy != CNT_W'(DEPTH - 1));

    // ------------------------------------------------------------ enqueue
    logic             in_any;
    logic             accept;
    logic             push_1;
    logic             push_2;
    logic [PTR_W-1:0] wr_idx_1;
    logic [PTR_W-1:0] wr_idx_2;
    logic [1:0]       n_push;
    entry_t           new_1;
    entry_t           new_2;

    assign in_any   = bus.in_valid_1 | bus.in_valid_2;
    assign accept   = in_any & in_ready_int;
    // Register 0 writes are discarded without taking a slot.
    assign push_1   = accept & bus.in_valid_1 & (bus.in_reg_1 != '0);
    assign push_2   = accept & bus.in_valid_2 & (bus.in_reg_2 != '0);
    assign wr_idx_1 = tail_reg[PTR_W-1:0];
    assign wr_idx_2 = wr_idx_1 + PTR_W'(push_1);
    assign n_push   = {1'b0, push_1} + {1'b0, push_2};
    assign new_1    = '{dst: bus.in_reg_1, data: bus.in_data_1};
    assign new_2    = '{dst: bus.in_reg_2, data: bus.in_data_2};

    always_ff @(posedge clk) begin
        if (push_1) begin
            mem[wr_idx_1] <= new_1;
        end
        if (push_2) begin
            mem[wr_idx_2] <= new_2;
        end
    end

    // ------------------------------------------------------------ retire
    logic [1:0]       n_pop;
    logic [PTR_W-1:0] rd_idx_0;
    logic [PTR_W-1:0] rd_idx_1;
    entry_t           pop_0;
    entry_t           pop_1;

    // Only entries present before this edge are eligible.
    always_comb begin
        n_pop = 2'd0;
        if (!wb_stall && !empty) begin
            n_pop = (occupancy == CNT_W'(1)) ? 2'd1 : 2'd2;
        end
    end

    assign rd_idx_0 = head_reg[PTR_W-1:0];
    assign rd_idx_1 = rd_idx_0 + PTR_W'(1);
    assign pop_0    = mem[rd_idx_0];
    assign pop_1    = mem[rd_idx_1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            head_reg <= head_reg + (PTR_W + 1)'(n_pop);
            tail_reg <= tail_reg + (PTR_W + 1)'(n_push);
            if (in_any && !in_ready_int) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Output registers are rewritten every edge, so each pop is presented
    // for exactly one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port1_reg  <= '0;
            port2_reg  <= '0;
            flag_1_reg <= WE_IDLE;
            flag_2_reg <= WE_IDLE;
        end else if (n_pop == 2'd2) begin
            port1_reg  <= pop_0;
            port2_reg  <= pop_1;
            flag_2_reg <= WE_ACTIVE;
            // Both going to the same register: only the younger value lands.
            flag_1_reg <= (pop_0.dst == pop_1.dst) ? WE_IDLE : WE_ACTIVE;
        end else if (n_pop == 2'd1) begin
            port1_reg  <= pop_0;
            port2_reg  <= '0;
            flag_1_reg <= WE_ACTIVE;
            flag_2_reg <= WE_IDLE;
        end else begin
            port1_reg  <= '0;
            port2_reg  <= '0;
            flag_1_reg <= WE_IDLE;
            flag_2_reg <= WE_IDLE;
        end
    end

    assign bus.in_ready         = in_ready_int;
    assign bus.write_reg_flag_1 = flag_1_reg;
    assign bus.write_reg_flag_2 = flag_2_reg;
    assign bus.write_reg_1      = port1_reg.dst;
    assign bus.write_reg_2      = port2_reg.dst;
    assign bus.write_data_1     = port1_reg.data;
    assign bus.write_data_2     = port2_reg.data;
    assign count                = occupancy;
    assign overflow             = overflow_reg;

    // ------------------------------------------------------------ lookup
    // Candidate order, oldest first: port 1, port 2, then queue head..tail.
    entry_t           cand [NCAND];
    logic [NCAND-1:0] cand_vld;

    assign cand[0]     = port1_reg;
    assign cand_vld[0] = (flag_1_reg == WE_ACTIVE);
    assign cand[1]     = port2_reg;
    assign cand_vld[1] = (flag_2_reg == WE_ACTIVE);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cand
            logic [PTR_W-1:0] idx;
            assign idx              = head_reg[PTR_W-1:0] + PTR_W'(gi);
            assign cand[gi + 2]     = mem[idx];
            assign cand_vld[gi + 2] = (occupancy > CNT_W'(gi));
        end
    endgenerate

    cola_escritura_lookup #(.NCAND(NCAND)) u_look_rs (
        .cand     (cand),
        .cand_vld (cand_vld),
        .look     (look_rs),
        .hit      (hit_rs),
        .data     (data_rs)
    );

    cola_escritura_lookup #(.NCAND(NCAND)) u_look_rt (
        .cand     (cand),
        .cand_vld (cand_vld),
        .look     (look_rt),
        .hit      (hit_rt),
        .data     (data_rt)
    );

endmodule

// File: tb/tb_cola_escritura_reg.sv
// Bench for the dual-issue writeback queue: directed vector table, a reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_cola_escritura_reg;
    import cola_escritura_reg_pkg::*;

    localparam int DEPTH = 4;
    localparam int NV    = 13;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_stall;
    logic [4:0]  look_rs;
    logic [4:0]  look_rt;
    logic        hit_rs;
    logic        hit_rt;
    logic [31:0] data_rs;
    logic [31:0] data_rt;
    logic [2:0]  count;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;

    cola_escritura_reg_if bus ();

    cola_escritura_reg #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .wb_stall (wb_stall),
        .look_rs  (look_rs),
        .look_rt  (look_rt),
        .hit_rs   (hit_rs),
        .hit_rt   (hit_rt),
        .data_rs  (data_rs),
        .data_rt  (data_rt),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic v1; logic [4:0] r1; logic [31:0] d1;
        logic v2; logic [4:0] r2; logic [31:0] d2;
        logic st; logic [4:0] lrs;
        logic [2:0] e_cnt; logic e_rdy; logic e_ovf;
        logic e_f1; logic e_c1; logic [4:0] e_r1; logic [31:0] e_d1;
        logic e_f2; logic [4:0] e_r2; logic [31:0] e_d2;
        logic e_hit; logic [31:0] e_drs;
    } vec_t;

    vec_t vec [NV];

    function automatic vec_t mk(int v1, int r1, int d1, int v2, int r2, int d2,
                                int st, int lrs, int cnt, int rdy, int ovf,
                                int f1, int c1, int pr1, int pd1,
                                int f2, int pr2, int pd2, int hit, int drs);
        vec_t v;
        v.v1 = 1'(v1); v.r1 = 5'(r1); v.d1 = 32'(d1);
        v.v2 = 1'(v2); v.r2 = 5'(r2); v.d2 = 32'(d2);
        v.st = 1'(st); v.lrs = 5'(lrs);
        v.e_cnt = 3'(cnt); v.e_rdy = 1'(rdy); v.e_ovf = 1'(ovf);
        v.e_f1 = 1'(f1); v.e_c1 = 1'(c1); v.e_r1 = 5'(pr1); v.e_d1 = 32'(pd1);
        v.e_f2 = 1'(f2); v.e_r2 = 5'(pr2); v.e_d2 = 32'(pd2);
        v.e_hit = 1'(hit); v.e_drs = 32'(drs);
        return v;
    endfunction

    // ---------------------------------------------------------------- helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                         input logic v2, input logic [4:0] r2, input logic [31:0] d2,
                         input logic st, input logic [4:0] lrs, input logic [4:0] lrt);
        bus.in_valid_1 = v1; bus.in_reg_1 = r1; bus.in_data_1 = d1;
        bus.in_valid_2 = v2; bus.in_reg_2 = r2; bus.in_data_2 = d2;
        wb_stall = st; look_rs = lrs; look_rt = lrt;
    endtask

    // ---------------------------------------------------------------- model
    // Pending writes as a program-ordered list; the bank ports as what was
    // retired on the last edge.
    entry_t mq[$];
    entry_t m_p1;
    entry_t m_p2;
    logic   m_f1;
    logic   m_f2;
    logic   m_same;
    logic   m_ovf;

    task automatic model_reset();
        mq.delete();
        m_p1 = '0; m_p2 = '0; m_f1 = 1'b1; m_f2 = 1'b1; m_same = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                              input logic v2, input logic [4:0] r2, input logic [31:0] d2,
                              input logic st);
        bit rdy;
        int n;
        rdy = (DEPTH - mq.size()) >= 2;
        m_p1 = '0; m_p2 = '0; m_f1 = 1'b1; m_f2 = 1'b1; m_same = 1'b0;
        if (!st) begin
            n = (mq.size() < 2) ? mq.size() : 2;
            if (n >= 1) begin m_p1 = mq.pop_front(); m_f1 = 1'b0; end
            if (n == 2) begin
                m_p2 = mq.pop_front(); m_f2 = 1'b0;
                if (m_p1.dst == m_p2.dst) begin m_f1 = 1'b1; m_same = 1'b1; end
            end
        end
        if (v1 || v2) begin
            if (!rdy) m_ovf = 1'b1;
            else begin
                if (v1 && r1 != 0) mq.push_back('{dst: r1, data: d1});
                if (v2 && r2 != 0) mq.push_back('{dst: r2, data: d2});
            end
        end
    endtask

    task automatic model_lookup(input logic [4:0] idx, output logic hit, output logic [31:0] val);
        hit = 1'b0; val = '0;
        if (idx == 0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].dst == idx) begin hit = 1'b1; val = mq[i].data; return; end
        end
        if (!m_f2 && m_p2.dst == idx) begin hit = 1'b1; val = m_p2.data; return; end
        if (!m_f1 && m_p1.dst == idx) begin hit = 1'b1; val = m_p1.data; end
    endtask

    task automatic compare_model(input int c);
        logic        eh;
        logic [31:0] ed;
        chk($sformatf("rnd%0d count", c), 32'(count), 32'(mq.size()));
        chk($sformatf("rnd%0d in_ready", c), 32'(bus.in_ready), 32'((DEPTH - mq.size()) >= 2));
        chk($sformatf("rnd%0d overflow", c), 32'(overflow), 32'(m_ovf));
        chk($sformatf("rnd%0d flag1", c), 32'(bus.write_reg_flag_1), 32'(m_f1));
        chk($sformatf("rnd%0d flag2", c), 32'(bus.write_reg_flag_2), 32'(m_f2));
        if (!m_same) begin
            chk($sformatf("rnd%0d reg1", c), 32'(bus.write_reg_1), 32'(m_p1.dst));
            chk($sformatf("rnd%0d data1", c), bus.write_data_1, m_p1.data);
        end
        chk($sformatf("rnd%0d reg2", c), 32'(bus.write_reg_2), 32'(m_p2.dst));
        chk($sformatf("rnd%0d data2", c), bus.write_data_2, m_p2.data);
        model_lookup(look_rs, eh, ed);
        chk($sformatf("rnd%0d hit_rs", c), 32'(hit_rs), 32'(eh));
        chk($sformatf("rnd%0d data_rs", c), data_rs, ed);
        model_lookup(look_rt, eh, ed);
        chk($sformatf("rnd%0d hit_rt", c), 32'(hit_rt), 32'(eh));
        chk($sformatf("rnd%0d data_rt", c), data_rt, ed);
    endtask

    // ---------------------------------------------------------------- test
    initial begin
        //            v1 r1  d1     v2 r2  d2     st lrs  cnt rdy ovf  f1 c1 r1 d1     f2 r2 d2     hit drs
        vec[0]  = mk(1,  8, 'h11,  1,  9, 'h22,  0,  8,   2, 1, 0,   1, 1, 0, 0,      1, 0, 0,     1, 'h11);
        vec[1]  = mk(0,  0, 0,     0,  0, 0,     0,  9,   0, 1, 0,   0, 1, 8, 'h11,   0, 9, 'h22,  1, 'h22);
        vec[2]  = mk(1,  8, 'hA,   1,  8, 'hB,   0,  8,   2, 1, 0,   1, 1, 0, 0,      1, 0, 0,     1, 'hB);
        vec[3]  = mk(0,  0, 0,     0,  0, 0,     0,  8,   0, 1, 0,   1, 0, 0, 0,      0, 8, 'hB,   1, 'hB);
        vec[4]  = mk(1, 10, 'h1,   1, 11, 'h2,   1, 10,   2, 1, 0,   1, 1, 0, 0,      1, 0, 0,     1, 'h1);
        vec[5]  = mk(1, 12, 'h3,   1, 13, 'h4,   1, 13,   4, 0, 0,   1, 1, 0, 0,      1, 0, 0,     1, 'h4);
        vec[6]  = mk(1, 14, 'h5,   0,  0, 0,     1, 14,   4, 0, 1,   1, 1, 0, 0,      1, 0, 0,     0, 0);
        vec[7]  = mk(0,  0, 0,     0,  0, 0,     0, 10,   2, 1, 1,   0, 1, 10, 'h1,   0, 11, 'h2,  1, 'h1);
        vec[8]  = mk(0,  0, 0,     0,  0, 0,     0, 11,   0, 1, 1,   0, 1, 12, 'h3,   0, 13, 'h4,  0, 0);
        vec[9]  = mk(0,  0, 0,     0,  0, 0,     0, 12,   0, 1, 1,   1, 1, 0, 0,      1, 0, 0,     0, 0);
        vec[10] = mk(1,  0, 'h55,  1,  5, 'h66,  0,  0,   1, 1, 1,   1, 1, 0, 0,      1, 0, 0,     0, 0);
        vec[11] = mk(0,  0, 0,     0,  0, 0,     0,  5,   0, 1, 1,   0, 1, 5, 'h66,   1, 0, 0,     1, 'h66);
        vec[12] = mk(0,  0, 0,     0,  0, 0,     0,  5,   0, 1, 1,   1, 1, 0, 0,      1, 0, 0,     0, 0);

        // Power-up reset
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 8, 8);
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset flag1", 32'(bus.write_reg_flag_1), 32'(1));
        chk("reset flag2", 32'(bus.write_reg_flag_2), 32'(1));
        chk("reset reg1", 32'(bus.write_reg_1), 32'(0));
        chk("reset data2", bus.write_data_2, 32'(0));
        chk("reset count", 32'(count), 32'(0));
        chk("reset in_ready", 32'(bus.in_ready), 32'(1));
        chk("reset overflow", 32'(overflow), 32'(0));
        chk("reset hit_rs", 32'(hit_rs), 32'(0));
        chk("reset data_rs", data_rs, 32'(0));
        $display("reset: flags %b/%b count %0d", bus.write_reg_flag_1, bus.write_reg_flag_2, count);
        reset_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            drive(vec[i].v1, vec[i].r1, vec[i].d1, vec[i].v2, vec[i].r2, vec[i].d2,
                  vec[i].st, vec[i].lrs, vec[i].lrs);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d count", i), 32'(count), 32'(vec[i].e_cnt));
            chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vec[i].e_rdy));
            chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(vec[i].e_ovf));
            chk($sformatf("v%0d flag1", i), 32'(bus.write_reg_flag_1), 32'(vec[i].e_f1));
            if (vec[i].e_c1) begin
                chk($sformatf("v%0d reg1", i), 32'(bus.write_reg_1), 32'(vec[i].e_r1));
                chk($sformatf("v%0d data1", i), bus.write_data_1, vec[i].e_d1);
            end
            chk($sformatf("v%0d flag2", i), 32'(bus.write_reg_flag_2), 32'(vec[i].e_f2));
            chk($sformatf("v%0d reg2", i), 32'(bus.write_reg_2), 32'(vec[i].e_r2));
            chk($sformatf("v%0d data2", i), bus.write_data_2, vec[i].e_d2);
            chk($sformatf("v%0d hit_rs", i), 32'(hit_rs), 32'(vec[i].e_hit));
            chk($sformatf("v%0d data_rs", i), data_rs, vec[i].e_drs);
            chk($sformatf("v%0d hit_rt", i), 32'(hit_rt), 32'(vec[i].e_hit));
            chk($sformatf("v%0d data_rt", i), data_rt, vec[i].e_drs);
            $display("vec %0d: count %0d p1 %b r%0d=%0h p2 %b r%0d=%0h look r%0d hit %b %0h",
                     i, count, bus.write_reg_flag_1, bus.write_reg_1, bus.write_data_1,
                     bus.write_reg_flag_2, bus.write_reg_2, bus.write_data_2,
                     look_rs, hit_rs, data_rs);
        end

        // Reset asserted mid-operation with entries queued and ports active
        drive(1, 1, 'h101, 1, 2, 'h102, 1, 3, 4);
        @(posedge clk);
        #1;
        chk("midrst fill count", 32'(count), 32'(2));
        drive(1, 3, 'h103, 1, 4, 'h104, 0, 3, 1);
        @(posedge clk);
        #1;
        chk("midrst pre flag1", 32'(bus.write_reg_flag_1), 32'(0));
        chk("midrst pre flag2", 32'(bus.write_reg_flag_2), 32'(0));
        chk("midrst pre count", 32'(count), 32'(2));
        chk("midrst pre data_rs", data_rs, 32'h103);
        drive(0, 0, 0, 0, 0, 0, 0, 3, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst flag1", 32'(bus.write_reg_flag_1), 32'(1));
        chk("midrst flag2", 32'(bus.write_reg_flag_2), 32'(1));
        chk("midrst count", 32'(count), 32'(0));
        chk("midrst in_ready", 32'(bus.in_ready), 32'(1));
        chk("midrst overflow", 32'(overflow), 32'(0));
        chk("midrst hit_rs", 32'(hit_rs), 32'(0));
        chk("midrst hit_rt", 32'(hit_rt), 32'(0));
        $display("mid-op reset: flags %b/%b count %0d", bus.write_reg_flag_1, bus.write_reg_flag_2, count);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("postrst%0d flag1", k), 32'(bus.write_reg_flag_1), 32'(1));
            chk($sformatf("postrst%0d flag2", k), 32'(bus.write_reg_flag_2), 32'(1));
            chk($sformatf("postrst%0d count", k), 32'(count), 32'(0));
            $display("post-reset cycle %0d: flags %b/%b count %0d", k,
                     bus.write_reg_flag_1, bus.write_reg_flag_2, count);
        end

        // Randomized traffic against the reference model
        model_reset();
        for (int c = 0; c < 300; c++) begin
            logic        v1, v2, st;
            logic [4:0]  r1, r2, l1, l2;
            logic [31:0] d1, d2;
            v1 = ($urandom_range(3, 0) != 0);
            v2 = ($urandom_range(3, 0) != 0);
            r1 = 5'($urandom_range(7, 0));
            r2 = 5'($urandom_range(7, 0));
            d1 = $urandom();
            d2 = $urandom();
            st = ($urandom_range(3, 0) == 0);
            l1 = 5'($urandom_range(7, 0));
            l2 = 5'($urandom_range(7, 0));
            drive(v1, r1, d1, v2, r2, d2, st, l1, l2);
            model_step(v1, r1, d1, v2, r2, d2, st);
            @(posedge clk);
            #1;
            compare_model(c);
            $display("rnd %0d: in %b r%0d %b r%0d st %b -> count %0d flags %b/%b",
                     c, v1, r1, v2, r2, st, count, bus.write_reg_flag_1, bus.write_reg_flag_2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
